// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg_pkg
//  Description : Shared CPU pipeline definitions. Holds the stage-register
//                state encoding and occupancy width so that the IF_ID, ID_EX,
//                EX_MEM and MEM_WB instances all agree on them.
//                Contents:
//                  OCC_W         - width of the occupancy count (0..2)
//                  stage_state_e - EMPTY / FULL / SKIDDED
//                  occ_of()      - state -> occupancy count
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,   // no entries held
        ST_FULL    = 2'd1,   // main entry only
        ST_SKIDDED = 2'd2    // main + skid entry
    } stage_state_e;

    function automatic logic [OCC_W-1:0] occ_of(input stage_state_e s);
        logic [OCC_W-1:0] n;
        case (s)
            ST_FULL:    n = 2'd1;
            ST_SKIDDED: n = 2'd2;
            default:    n = 2'd0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_slot
//  Description : One pipeline entry register (datapath + control payload)
//                with synchronous load and clear.
//                Ports:
//                  clk     - clock, rising edge
//                  reset   - synchronous, active-low; zeroes the entry
//                  clear_i - zero the entry (has priority over load)
//                  load_i  - capture d_i
//                  d_i     - incoming payload
//                  q_o     - held payload
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Valid/ready pipeline stage register carrying a datapath and
//                a control payload. SKID=1 builds a two-entry skid stage with
//                a registered in_ready; SKID=0 builds a single-entry stage
//                whose in_ready is combinational from out_ready. One cycle
//                latency, one entry per cycle throughput, strict FIFO order.
//                Ports:
//                  clk, reset (sync, active-low), flush (squash all entries)
//                  in_valid / in_ready / in_data / in_ctrl    - upstream
//                  out_valid / out_ready / out_data / out_ctrl - downstream
//                  occupancy - entries held (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy
);

    localparam int SLOT_W = DATA_W + CTRL_W;

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic              in_xfer;
    logic              out_xfer;
    logic [SLOT_W-1:0] in_payload;
    logic [SLOT_W-1:0] main_d;
    logic [SLOT_W-1:0] main_q;
    logic [SLOT_W-1:0] skid_q;
    logic              main_load;
    logic              main_clear;

    // A flushed input is dropped even though in_ready may be high.
    assign in_xfer    = in_valid & in_ready & ~flush;
    assign out_xfer   = out_valid & out_ready;
    assign in_payload = {in_ctrl, in_data};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) state_d = ST_FULL;
                end
                ST_FULL: begin
                    if (out_xfer && !in_xfer) begin
                        state_d = ST_EMPTY;
                    end else if (!out_xfer && in_xfer && (SKID != 0)) begin
                        state_d = ST_SKIDDED;
                    end
                end
                ST_SKIDDED: begin
                    if (out_xfer) state_d = ST_FULL;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Main entry: refilled from the skid entry when draining SKIDDED,
    // otherwise from the input. Cleared when it leaves without a successor
    // so that an idle stage holds no stale payload.
    // ------------------------------------------------------------------
    assign main_d    = (state_q == ST_SKIDDED) ? skid_q : in_payload;
    assign main_load = ((state_q == ST_EMPTY)   && in_xfer)
                     | ((state_q == ST_FULL)    && in_xfer && out_xfer)
                     | ((state_q == ST_SKIDDED) && out_xfer);
    assign main_clear = flush | ((state_q == ST_FULL) && out_xfer && !in_xfer);

    pipe_slot #(
        .W (SLOT_W)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .clear_i (main_clear),
        .load_i  (main_load),
        .d_i     (main_d),
        .q_o     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic skid_load;
            logic skid_clear;
            logic in_ready_q;

            assign skid_load  = (state_q == ST_FULL) && in_xfer && !out_xfer;
            assign skid_clear = flush | ((state_q == ST_SKIDDED) && out_xfer);

            pipe_slot #(
                .W (SLOT_W)
            ) u_skid (
                .clk     (clk),
                .reset   (reset),
                .clear_i (skid_clear),
                .load_i  (skid_load),
                .d_i     (in_payload),
                .q_o     (skid_q)
            );

            // Registered from the next state: no path from out_ready. Held
            // low through reset so nothing is accepted until one clean edge.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    in_ready_q <= 1'b0;
                end else begin
                    in_ready_q <= (state_d != ST_SKIDDED);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign skid_q   = '0;
            assign in_ready = (state_q == ST_EMPTY) | out_ready;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs: a bubble presents all-zero payload downstream.
    // ------------------------------------------------------------------
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_valid ? main_q[DATA_W-1:0]      : '0;
    assign out_ctrl  = out_valid ? main_q[SLOT_W-1:DATA_W] : '0;
    assign occupancy = occ_of(state_q);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Directed self-checking bench for pipe_stage_reg, with one
//                SKID=1 instance (u_dut1) and one SKID=0 instance (u_dut0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;

    logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] in_data1, out_data1;
    logic [2:0]  in_ctrl1, out_ctrl1;
    logic [1:0]  occ1;

    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [31:0] in_data0, out_data0;
    logic [2:0]  in_ctrl0, out_ctrl0;
    logic [1:0]  occ0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .SKID(1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .in_ctrl(in_ctrl1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .out_ctrl(out_ctrl1), .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .SKID(0)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .in_ctrl(in_ctrl0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occ0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; inputs change and outputs are sampled
    // 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] d, input logic [2:0] c);
        in_valid1 = 1'b1; in_data1 = d; in_ctrl1 = c;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        flush1 = 1'b0; in_valid1 = 1'b1; in_data1 = 32'hDEADBEEF; in_ctrl1 = 3'd7; out_ready1 = 1'b1;
        flush0 = 1'b0; in_valid0 = 1'b1; in_data0 = 32'hDEADBEEF; in_ctrl0 = 3'd7; out_ready0 = 1'b1;

        // ---- Reset held two edges with live input ----
        tick(); tick();
        chk("rst1_valid", {63'd0, out_valid1}, 64'd0);
        chk("rst1_data",  {32'd0, out_data1},  64'd0);
        chk("rst1_ctrl",  {61'd0, out_ctrl1},  64'd0);
        chk("rst1_occ",   {62'd0, occ1},       64'd0);
        chk("rst1_ready", {63'd0, in_ready1},  64'd0);
        chk("rst0_valid", {63'd0, out_valid0}, 64'd0);
        chk("rst0_occ",   {62'd0, occ0},       64'd0);
        chk("rst0_ready", {63'd0, in_ready0},  64'd1);

        reset = 1'b1; in_valid1 = 1'b0; in_valid0 = 1'b0;
        tick();
        chk("post_rst_ready1", {63'd0, in_ready1}, 64'd1);
        chk("post_rst_occ1",   {62'd0, occ1},      64'd0);

        // ---- SKID=1 streaming ----
        out_ready1 = 1'b1;
        push1(32'h1, 3'd1);
        chk("str_d1",  {32'd0, out_data1}, 64'h1);
        chk("str_c1",  {61'd0, out_ctrl1}, 64'd1);
        chk("str_rdy1", {63'd0, in_ready1}, 64'd1);
        push1(32'h2, 3'd2);
        chk("str_d2",  {32'd0, out_data1}, 64'h2);
        chk("str_rdy2", {63'd0, in_ready1}, 64'd1);
        push1(32'h3, 3'd3);
        chk("str_d3",  {32'd0, out_data1}, 64'h3);
        chk("str_occ3", {62'd0, occ1},     64'd1);
        in_valid1 = 1'b0;
        tick();
        chk("str_drain_valid", {63'd0, out_valid1}, 64'd0);
        chk("str_drain_data",  {32'd0, out_data1},  64'd0);

        // ---- SKID=1 backpressure ----
        out_ready1 = 1'b0;
        push1(32'hA, 3'd5);
        chk("bp_occ1",  {62'd0, occ1},      64'd1);
        chk("bp_rdy1",  {63'd0, in_ready1}, 64'd1);
        push1(32'hB, 3'd6);
        chk("bp_occ2",  {62'd0, occ1},      64'd2);
        chk("bp_rdy0",  {63'd0, in_ready1}, 64'd0);
        chk("bp_headA", {32'd0, out_data1}, 64'hA);
        push1(32'hEE, 3'd4);        // refused: in_ready low
        chk("bp_hold_occ", {62'd0, occ1},      64'd2);
        chk("bp_hold_A",   {32'd0, out_data1}, 64'hA);
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        tick();
        chk("bp_headB",    {32'd0, out_data1}, 64'hB);
        chk("bp_ctrlB",    {61'd0, out_ctrl1}, 64'd6);
        chk("bp_rdy_back", {63'd0, in_ready1}, 64'd1);
        chk("bp_occ_back", {62'd0, occ1},      64'd1);
        tick();
        chk("bp_empty", {63'd0, out_valid1}, 64'd0);

        // ---- SKID=1 flush with same-cycle input ----
        out_ready1 = 1'b0;
        push1(32'hA, 3'd5);
        push1(32'hB, 3'd6);
        chk("fl_pre_occ", {62'd0, occ1}, 64'd2);
        flush1 = 1'b1; in_valid1 = 1'b1; in_data1 = 32'hC; in_ctrl1 = 3'd7;
        tick();
        chk("fl_occ",   {62'd0, occ1},       64'd0);
        chk("fl_valid", {63'd0, out_valid1}, 64'd0);
        chk("fl_ctrl",  {61'd0, out_ctrl1},  64'd0);
        chk("fl_data",  {32'd0, out_data1},  64'd0);
        flush1 = 1'b0; in_valid1 = 1'b0;
        tick();
        chk("fl_noC_occ",   {62'd0, occ1},       64'd0);
        chk("fl_noC_valid", {63'd0, out_valid1}, 64'd0);

        // ---- SKID=1 reset mid-SKIDDED ----
        push1(32'h11, 3'd1);
        push1(32'h12, 3'd2);
        chk("rs_pre_occ", {62'd0, occ1}, 64'd2);
        in_valid1 = 1'b0; reset = 1'b0; flush1 = 1'b1;
        tick();
        chk("rs_occ",   {62'd0, occ1},       64'd0);
        chk("rs_valid", {63'd0, out_valid1}, 64'd0);
        chk("rs_data",  {32'd0, out_data1},  64'd0);
        chk("rs_ctrl",  {61'd0, out_ctrl1},  64'd0);
        chk("rs_rdy",   {63'd0, in_ready1},  64'd0);
        reset = 1'b1; flush1 = 1'b0;
        tick();
        out_ready1 = 1'b1;
        push1(32'h5, 3'd3);
        chk("rs_five_data", {32'd0, out_data1}, 64'h5);
        chk("rs_five_occ",  {62'd0, occ1},      64'd1);
        in_valid1 = 1'b0;
        tick();
        chk("rs_five_alone", {63'd0, out_valid1}, 64'd0);

        // ---- SKID=0 single-entry stage ----
        out_ready0 = 1'b0; in_valid0 = 1'b1; in_data0 = 32'h21; in_ctrl0 = 3'd3;
        #1;
        chk("s0_empty_rdy", {63'd0, in_ready0}, 64'd1);
        tick();
        chk("s0_head21", {32'd0, out_data0}, 64'h21);
        chk("s0_occ1",   {62'd0, occ0},      64'd1);
        in_data0 = 32'h22; in_ctrl0 = 3'd4;
        #1;
        chk("s0_full_rdy0", {63'd0, in_ready0}, 64'd0);
        tick();
        chk("s0_hold21", {32'd0, out_data0}, 64'h21);
        chk("s0_occ_cap", {62'd0, occ0},     64'd1);
        out_ready0 = 1'b1;
        #1;
        chk("s0_full_rdy1", {63'd0, in_ready0}, 64'd1);
        tick();
        chk("s0_head22", {32'd0, out_data0}, 64'h22);
        chk("s0_ctrl22", {61'd0, out_ctrl0}, 64'd4);
        chk("s0_occ_22", {62'd0, occ0},      64'd1);
        in_data0 = 32'h23; in_ctrl0 = 3'd5;
        tick();
        chk("s0_head23", {32'd0, out_data0}, 64'h23);
        in_valid0 = 1'b0;
        tick();
        chk("s0_empty_valid", {63'd0, out_valid0}, 64'd0);
        chk("s0_empty_data",  {32'd0, out_data0},  64'd0);
        chk("s0_empty_occ",   {62'd0, occ0},       64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
